seq_divider: RTL and testbench

Unsigned restoring divider, one quotient bit per clock. It is the inverse companion to the Vedic multiplier datapath. It accepts a WIDTH-bit dividend and divisor under a start/done handshake and returns quotient and remainder after a fixed latency. Each iteration's compare-subtract is built from half/full-subtractor cells, mirroring the adder cells used on the multiply side.

---
 rtl/seq_divider_pkg.sv | 14 +
 rtl/seq_divider_div_step.sv | 36 +++
 rtl/seq_divider.sv | 98 +++++++++
 tb/tb_seq_divider.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared constants for the divider datapath: FSM encoding and default operand width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_divider_pkg;

   // Operand width shared with the multiplier side
   localparam int DEFAULT_WIDTH = 32;

   // FSM encoding kept as plain 2-bit constants for legacy tool compatibility
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: trial subtract of the divisor from the partial remainder.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle by the parent.
module div_step
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH:0]   r,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic             qbit
);

   logic [WIDTH:0]   t;
   logic [WIDTH-1:0] bor;

   // Half subtractor at the LSB: no borrow comes in
   assign t[0]   = r[0] ^ divisor[0];
   assign bor[0] = ~r[0] & divisor[0];

   // Ripple borrow chain of full-subtractor cells
   genvar i;
   for (i = 1; i < WIDTH; i++) begin : g_fs
      assign t[i]   = r[i] ^ divisor[i] ^ bor[i-1];
      assign bor[i] = (~r[i] & divisor[i]) | (~(r[i] ^ divisor[i]) & bor[i-1]);
   end

   // Top bit subtracts an implicit zero; its value is the sign of the trial result
   assign t[WIDTH] = r[WIDTH] ^ bor[WIDTH-1];

   // Non-negative trial result means the divisor fits: keep it, else restore
   assign qbit     = ~t[WIDTH];
   assign rem_next = qbit ? t[WIDTH-1:0] : r[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Unsigned restoring divider producing one quotient bit per clock.
// Latency: done pulses WIDTH+1 cycles after an accepted start (1 cycle for divide-by-zero).
// Backpressure: start is only taken while ready=1; starts while busy or done are dropped.
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   logic [1:0]       state;
   logic [WIDTH-1:0] dq;       // dividend shifts out of the top, quotient shifts in at the bottom
   logic [WIDTH-1:0] dvs;
   logic [WIDTH-1:0] rem;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] rem_next;
   logic             qbit;

   div_step #(.WIDTH(WIDTH)) u_step (
      .r        ({rem, dq[WIDTH-1]}),
      .divisor  (dvs),
      .rem_next (rem_next),
      .qbit     (qbit)
   );

   assign ready = (state == ST_IDLE);
   assign busy  = (state == ST_CALC);

   // FSM, iteration counter, shift registers and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         dq          <= '0;
         dvs         <= '0;
         rem         <= '0;
         count       <= '0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (divisor != '0) begin
                     dq          <= dividend;
                     dvs         <= divisor;
                     rem         <= '0;
                     count       <= '0;
                     div_by_zero <= 1'b0;
                     state       <= ST_CALC;
                  end else begin
                     // Divide-by-zero skips the iterations; DONE publishes dq/rem as-is
                     dq          <= '1;
                     rem         <= dividend;
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                     state       <= ST_DONE;
                  end
               end
            end
            ST_CALC: begin
               dq    <= {dq[WIDTH-2:0], qbit};
               rem   <= rem_next;
               count <= count + 1'b1;
               if (count == CW'(WIDTH - 1)) begin
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               done      <= 1'b1;
               quotient  <= dq;
               remainder <= rem;
               state     <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed corner cases plus randomized back-to-back divisions.
// Expected results come from plain / and % arithmetic; a monitor checks each done pulse.
// Latency is checked against the accept edge of each start.
module tb_seq_divider;

   localparam int W = 32;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dbz;
      int           due;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         ready, busy, done, div_by_zero;
   logic [W-1:0] quotient, remainder;

   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;
   int   n_acc = 0;
   int   n_done = 0;
   exp_t exp_q[$];

   seq_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .ready       (ready),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
      n_chk++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
   endtask

   // Behavioural reference: arithmetic division, with the divide-by-zero convention
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int acc);
      exp_t e;
      e.a = a;
      e.b = b;
      if (b == 0) begin
         e.q   = '1;
         e.r   = a;
         e.dbz = 1'b1;
         e.due = acc + 1;
      end else begin
         e.q   = a / b;
         e.r   = a % b;
         e.dbz = 1'b0;
         e.due = acc + W + 1;
      end
      return e;
   endfunction

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
      int n = 0;
      @(negedge clk);
      while (!ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!ready) begin
         check("ready_timeout", 64'(ready), 64'd1);
         return;
      end
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
      exp_q.push_back(model(a, b, cyc));
      n_acc++;
   endtask

   function automatic logic [W-1:0] rand_operand();
      case ($urandom_range(0, 9))
         0:       return '0;
         1, 2, 3: return W'($urandom_range(1, 15));
         4, 5, 6: return W'($urandom >> $urandom_range(0, 31));
         default: return W'($urandom);
      endcase
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (done) begin
         n_done++;
         if (exp_q.size() == 0) begin
            check("spurious_done", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("quotient", 64'(quotient), 64'(e.q));
            check("remainder", 64'(remainder), 64'(e.r));
            check("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
            check("latency", 64'(cyc), 64'(e.due));
            if (!e.dbz) begin
               check("invariant", 64'(quotient) * 64'(e.b) + 64'(remainder), 64'(e.a));
               check("rem_lt_div", 64'(remainder < e.b), 64'd1);
            end
         end
      end
   end

   initial begin
      int n;
      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", 64'(ready), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_quotient", 64'(quotient), 64'd0);
      check("rst_remainder", 64'(remainder), 64'd0);
      check("rst_dbz", 64'(div_by_zero), 64'd0);
      rst = 1'b0;

      // Directed cases
      issue(32'd100, 32'd7);
      issue(32'hFFFF_FFFF, 32'd1);
      issue(32'd5, 32'd9);
      issue(32'd1234, 32'd0);

      // Start while busy must be ignored
      issue(32'd100, 32'd7);
      repeat (5) @(negedge clk);
      check("busy_ready", 64'(ready), 64'd0);
      check("busy_busy", 64'(busy), 64'd1);
      start    = 1'b1;
      dividend = 32'd50;
      divisor  = 32'd5;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("busy_ignored_ready", 64'(ready), 64'd0);

      // Reset mid-calculation aborts without a done pulse
      issue(32'd1000, 32'd3);
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      n_acc--;
      check("abort_ready", 64'(ready), 64'd1);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_quotient", 64'(quotient), 64'd0);
      check("abort_remainder", 64'(remainder), 64'd0);
      check("abort_dbz", 64'(div_by_zero), 64'd0);
      repeat (40) @(posedge clk);
      issue(32'd81, 32'd9);

      // Randomized back-to-back divisions
      for (int k = 0; k < 1500; k++) begin
         issue(rand_operand(), rand_operand());
      end

      // Drain outstanding results
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      check("drain", 64'(exp_q.size()), 64'd0);
      repeat (3) @(posedge clk);
      check("done_count", 64'(n_done), 64'(n_acc));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
